reservation_station_age_ordered: RTL and testbench

//  Parametrised reservation station for one functional unit (ALU or LS) between ROB dispatch and the FU.

---
 rtl/reservation_station_age_ordered.sv | 199 +++++++++++++++++++
 tb/tb_reservation_station_age_ordered.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_age_ordered.sv
// Age-ordered reservation station: holds dispatched ops, wakes operands from result broadcasts,
// and issues the ready entry closest to the ROB head.
package reservation_station_age_ordered_pkg;
   typedef logic [3:0] nzcv_t;
   typedef enum logic [3:0] {
      FuAdd, FuSub, FuAnd, FuOr, FuXor, FuLsl, FuLsr, FuAsr, FuMul, FuLoad, FuStore
   } fu_op_t;
endpackage

module reservation_station_age_ordered
   import reservation_station_age_ordered_pkg::*;
#(
   parameter int unsigned RS_SIZE      = 8,
   parameter int unsigned RS_IDX_SIZE  = 3,
   parameter int unsigned NUM_BCAST    = 2,
   parameter int unsigned GPR_SIZE     = 64,
   parameter int unsigned ROB_IDX_SIZE = 4
) (
   input  logic                            in_clk,
   input  logic                            in_rst_n,
   input  logic                            in_ins_valid,
   output logic                            out_ins_ready,
   input  fu_op_t                          in_ins_op,
   input  logic [ROB_IDX_SIZE-1:0]         in_ins_dst,
   input  logic [1:0]                      in_ins_src_valid,
   input  logic [2*ROB_IDX_SIZE-1:0]       in_ins_src_tag,
   input  logic [2*GPR_SIZE-1:0]           in_ins_src_value,
   input  logic                            in_ins_uses_nzcv,
   input  logic                            in_ins_nzcv_valid,
   input  logic [ROB_IDX_SIZE-1:0]         in_ins_nzcv_tag,
   input  nzcv_t                           in_ins_nzcv,
   input  logic                            in_ins_set_nzcv,
   input  logic [NUM_BCAST-1:0]            in_bc_valid,
   input  logic [NUM_BCAST*ROB_IDX_SIZE-1:0] in_bc_tag,
   input  logic [NUM_BCAST*GPR_SIZE-1:0]   in_bc_value,
   input  logic [NUM_BCAST-1:0]            in_bc_set_nzcv,
   input  logic [NUM_BCAST*4-1:0]          in_bc_nzcv,
   input  logic [ROB_IDX_SIZE-1:0]         in_rob_head,
   input  logic                            in_flush,
   input  logic [ROB_IDX_SIZE-1:0]         in_flush_tag,
   output logic                            out_iss_valid,
   input  logic                            in_iss_ready,
   output fu_op_t                          out_iss_op,
   output logic [ROB_IDX_SIZE-1:0]         out_iss_dst,
   output logic [GPR_SIZE-1:0]             out_iss_val_a,
   output logic [GPR_SIZE-1:0]             out_iss_val_b,
   output nzcv_t                           out_iss_nzcv,
   output logic                            out_iss_set_nzcv,
   output logic [RS_IDX_SIZE:0]            out_count
);

   typedef struct packed {
      logic                             valid;
      fu_op_t                           op;
      logic [ROB_IDX_SIZE-1:0]          dst;
      logic [1:0]                       src_valid;
      logic [1:0][ROB_IDX_SIZE-1:0]     src_tag;
      logic [1:0][GPR_SIZE-1:0]         src_val;
      logic                             uses_nzcv;
      logic                             nzcv_valid;
      logic [ROB_IDX_SIZE-1:0]          nzcv_tag;
      nzcv_t                            nzcv;
      logic                             set_nzcv;
   } entry_t;

   entry_t                  r_ent   [RS_SIZE];
   entry_t                  w_ent_d [RS_SIZE];
   entry_t                  w_new;
   entry_t                  w_sel;
   logic [RS_SIZE-1:0]      w_valid;
   logic [RS_SIZE-1:0]      w_ready;
   logic [RS_IDX_SIZE-1:0]  w_free_idx;
   logic [RS_IDX_SIZE-1:0]  w_sel_idx;
   logic [ROB_IDX_SIZE-1:0] w_sel_age;
   logic [ROB_IDX_SIZE-1:0] w_flush_age;
   logic                    w_any_ready;
   logic                    w_ins_fire;
   logic                    w_iss_fire;
   logic [RS_IDX_SIZE:0]    w_count;

   function automatic logic [ROB_IDX_SIZE-1:0] f_age(input logic [ROB_IDX_SIZE-1:0] tag);
      return tag - in_rob_head;
   endfunction

   // Ports scanned high to low so the lowest matching port overwrites last and wins.
   function automatic entry_t f_wakeup(input entry_t e);
      entry_t r;
      r = e;
      for (int p = NUM_BCAST - 1; p >= 0; p--) begin
         if (in_bc_valid[p]) begin
            for (int s = 0; s < 2; s++) begin
               if (!e.src_valid[s] && e.src_tag[s] == in_bc_tag[p*ROB_IDX_SIZE +: ROB_IDX_SIZE]) begin
                  r.src_valid[s] = 1'b1;
                  r.src_val[s]   = in_bc_value[p*GPR_SIZE +: GPR_SIZE];
               end
            end
            if (e.uses_nzcv && !e.nzcv_valid && in_bc_set_nzcv[p] &&
                e.nzcv_tag == in_bc_tag[p*ROB_IDX_SIZE +: ROB_IDX_SIZE]) begin
               r.nzcv_valid = 1'b1;
               r.nzcv       = in_bc_nzcv[p*4 +: 4];
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      w_count = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         w_valid[i] = r_ent[i].valid;
         w_ready[i] = r_ent[i].valid & r_ent[i].src_valid[0] & r_ent[i].src_valid[1] &
                      (~r_ent[i].uses_nzcv | r_ent[i].nzcv_valid);
         w_count    = w_count + {{RS_IDX_SIZE{1'b0}}, r_ent[i].valid};
      end
   end

   always_comb begin
      w_free_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!w_valid[i]) w_free_idx = RS_IDX_SIZE'(i);
      end
   end

   always_comb begin
      w_sel_idx   = '0;
      w_sel_age   = '0;
      w_any_ready = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (w_ready[i] && (!w_any_ready || f_age(r_ent[i].dst) < w_sel_age)) begin
            w_any_ready = 1'b1;
            w_sel_idx   = RS_IDX_SIZE'(i);
            w_sel_age   = f_age(r_ent[i].dst);
         end
      end
   end

   assign w_sel         = r_ent[w_sel_idx];
   assign out_ins_ready = in_rst_n & ~in_flush & ~(&w_valid);
   assign out_iss_valid = ~in_flush & w_any_ready;
   assign w_ins_fire    = in_ins_valid & out_ins_ready;
   assign w_iss_fire    = out_iss_valid & in_iss_ready;
   assign w_flush_age   = f_age(in_flush_tag);
   assign out_count     = w_count;

   always_comb begin
      entry_t e;
      e            = '0;
      e.valid      = 1'b1;
      e.op         = in_ins_op;
      e.dst        = in_ins_dst;
      e.src_valid  = in_ins_src_valid;
      e.src_tag[0] = in_ins_src_tag[0 +: ROB_IDX_SIZE];
      e.src_tag[1] = in_ins_src_tag[ROB_IDX_SIZE +: ROB_IDX_SIZE];
      e.src_val[0] = in_ins_src_value[0 +: GPR_SIZE];
      e.src_val[1] = in_ins_src_value[GPR_SIZE +: GPR_SIZE];
      e.uses_nzcv  = in_ins_uses_nzcv;
      e.nzcv_valid = in_ins_nzcv_valid;
      e.nzcv_tag   = in_ins_nzcv_tag;
      e.nzcv       = in_ins_nzcv;
      e.set_nzcv   = in_ins_set_nzcv;
      w_new        = f_wakeup(e);
   end

   // Free slot is taken from registered state, so a slot vacated by this cycle's issue is not reused.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         w_ent_d[i] = f_wakeup(r_ent[i]);
         if (in_flush && f_age(r_ent[i].dst) > w_flush_age) w_ent_d[i].valid = 1'b0;
         if (w_iss_fire && w_sel_idx == RS_IDX_SIZE'(i)) w_ent_d[i].valid = 1'b0;
         if (w_ins_fire && w_free_idx == RS_IDX_SIZE'(i)) w_ent_d[i] = w_new;
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= w_ent_d[i];
      end
   end

   always_comb begin
      out_iss_op       = FuAdd;
      out_iss_dst      = '0;
      out_iss_val_a    = '0;
      out_iss_val_b    = '0;
      out_iss_nzcv     = '0;
      out_iss_set_nzcv = 1'b0;
      if (out_iss_valid) begin
         out_iss_op       = w_sel.op;
         out_iss_dst      = w_sel.dst;
         out_iss_val_a    = w_sel.src_val[0];
         out_iss_val_b    = w_sel.src_val[1];
         out_iss_nzcv     = w_sel.nzcv;
         out_iss_set_nzcv = w_sel.set_nzcv;
      end
   end

endmodule

// File: tb/tb_reservation_station_age_ordered.sv
// Directed bench for reservation_station_age_ordered: ordering, wakeup, bypass, full, flush, reset.
module tb_reservation_station_age_ordered;
   import reservation_station_age_ordered_pkg::*;

   logic         in_clk = 1'b0;
   logic         in_rst_n;
   logic         in_ins_valid;
   logic         out_ins_ready;
   fu_op_t       in_ins_op;
   logic [3:0]   in_ins_dst;
   logic [1:0]   in_ins_src_valid;
   logic [7:0]   in_ins_src_tag;
   logic [127:0] in_ins_src_value;
   logic         in_ins_uses_nzcv;
   logic         in_ins_nzcv_valid;
   logic [3:0]   in_ins_nzcv_tag;
   nzcv_t        in_ins_nzcv;
   logic         in_ins_set_nzcv;
   logic [1:0]   in_bc_valid;
   logic [7:0]   in_bc_tag;
   logic [127:0] in_bc_value;
   logic [1:0]   in_bc_set_nzcv;
   logic [7:0]   in_bc_nzcv;
   logic [3:0]   in_rob_head;
   logic         in_flush;
   logic [3:0]   in_flush_tag;
   logic         out_iss_valid;
   logic         in_iss_ready;
   fu_op_t       out_iss_op;
   logic [3:0]   out_iss_dst;
   logic [63:0]  out_iss_val_a;
   logic [63:0]  out_iss_val_b;
   nzcv_t        out_iss_nzcv;
   logic         out_iss_set_nzcv;
   logic [3:0]   out_count;

   int n_tests = 0;
   int n_fail  = 0;

   reservation_station_age_ordered dut (
      .in_clk(in_clk), .in_rst_n(in_rst_n),
      .in_ins_valid(in_ins_valid), .out_ins_ready(out_ins_ready),
      .in_ins_op(in_ins_op), .in_ins_dst(in_ins_dst),
      .in_ins_src_valid(in_ins_src_valid), .in_ins_src_tag(in_ins_src_tag),
      .in_ins_src_value(in_ins_src_value), .in_ins_uses_nzcv(in_ins_uses_nzcv),
      .in_ins_nzcv_valid(in_ins_nzcv_valid), .in_ins_nzcv_tag(in_ins_nzcv_tag),
      .in_ins_nzcv(in_ins_nzcv), .in_ins_set_nzcv(in_ins_set_nzcv),
      .in_bc_valid(in_bc_valid), .in_bc_tag(in_bc_tag), .in_bc_value(in_bc_value),
      .in_bc_set_nzcv(in_bc_set_nzcv), .in_bc_nzcv(in_bc_nzcv),
      .in_rob_head(in_rob_head), .in_flush(in_flush), .in_flush_tag(in_flush_tag),
      .out_iss_valid(out_iss_valid), .in_iss_ready(in_iss_ready),
      .out_iss_op(out_iss_op), .out_iss_dst(out_iss_dst),
      .out_iss_val_a(out_iss_val_a), .out_iss_val_b(out_iss_val_b),
      .out_iss_nzcv(out_iss_nzcv), .out_iss_set_nzcv(out_iss_set_nzcv),
      .out_count(out_count)
   );

   always #5 in_clk = ~in_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic ins(input logic [3:0] dst, input logic [1:0] sv, input logic [3:0] ta,
                      input logic [3:0] tb_tag, input logic [63:0] va, input logic [63:0] vb);
      in_ins_valid     = 1'b1;
      in_ins_dst       = dst;
      in_ins_src_valid = sv;
      in_ins_src_tag   = {tb_tag, ta};
      in_ins_src_value = {vb, va};
      tick();
      in_ins_valid      = 1'b0;
      in_ins_uses_nzcv  = 1'b0;
      in_ins_nzcv_valid = 1'b0;
      #1;
   endtask

   task automatic bcast(input int p, input logic [3:0] tag, input logic [63:0] val,
                        input logic setn, input logic [3:0] nz);
      in_bc_valid[p]          = 1'b1;
      in_bc_tag[p*4 +: 4]     = tag;
      in_bc_value[p*64 +: 64] = val;
      in_bc_set_nzcv[p]       = setn;
      in_bc_nzcv[p*4 +: 4]    = nz;
   endtask

   task automatic issue_one();
      in_iss_ready = 1'b1;
      tick();
      in_iss_ready = 1'b0;
      #1;
   endtask

   initial begin
      in_rst_n = 1'b0; in_ins_valid = 1'b0; in_ins_op = FuAdd; in_ins_dst = '0;
      in_ins_src_valid = '0; in_ins_src_tag = '0; in_ins_src_value = '0;
      in_ins_uses_nzcv = 1'b0; in_ins_nzcv_valid = 1'b0; in_ins_nzcv_tag = '0;
      in_ins_nzcv = '0; in_ins_set_nzcv = 1'b0; in_bc_valid = '0; in_bc_tag = '0;
      in_bc_value = '0; in_bc_set_nzcv = '0; in_bc_nzcv = '0; in_rob_head = '0;
      in_flush = 1'b0; in_flush_tag = '0; in_iss_ready = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_count", 64'(out_count), 0);
      check("rst_ins_ready", 64'(out_ins_ready), 0);
      check("rst_iss_valid", 64'(out_iss_valid), 0);
      in_rst_n = 1'b1;
      #1;
      check("post_rst_ins_ready", 64'(out_ins_ready), 1);

      // Single ready insert and issue
      in_ins_op = FuSub;
      ins(4'd3, 2'b11, 4'd0, 4'd0, 64'd5, 64'd7);
      check("t1_iss_valid", 64'(out_iss_valid), 1);
      check("t1_op", 64'(out_iss_op), 64'(FuSub));
      check("t1_dst", 64'(out_iss_dst), 3);
      check("t1_val_a", out_iss_val_a, 5);
      check("t1_val_b", out_iss_val_b, 7);
      check("t1_count", 64'(out_count), 1);
      in_ins_op = FuAdd;
      issue_one();
      check("t1_count_after", 64'(out_count), 0);
      check("t1_iss_valid_after", 64'(out_iss_valid), 0);

      // Oldest first
      ins(4'd6, 2'b11, 4'd0, 4'd0, 64'd60, 64'd61);
      ins(4'd2, 2'b11, 4'd0, 4'd0, 64'd20, 64'd21);
      check("t2_first_dst", 64'(out_iss_dst), 2);
      check("t2_count", 64'(out_count), 2);
      issue_one();
      check("t2_second_dst", 64'(out_iss_dst), 6);
      check("t2_second_val_a", out_iss_val_a, 60);
      issue_one();
      check("t2_count_after", 64'(out_count), 0);

      // Age wraps around the ROB head
      in_rob_head = 4'd14;
      ins(4'd1, 2'b11, 4'd0, 4'd0, 64'd1, 64'd1);
      ins(4'd15, 2'b11, 4'd0, 4'd0, 64'd2, 64'd2);
      check("wrap_first_dst", 64'(out_iss_dst), 15);
      issue_one();
      check("wrap_second_dst", 64'(out_iss_dst), 1);
      issue_one();
      in_rob_head = 4'd0;

      // Wakeup on port 1
      ins(4'd5, 2'b01, 4'd0, 4'd4, 64'd1, 64'd0);
      check("t3_not_ready", 64'(out_iss_valid), 0);
      bcast(1, 4'd4, 64'h2A, 1'b0, 4'h0);
      tick();
      in_bc_valid = '0;
      #1;
      check("t3_iss_valid", 64'(out_iss_valid), 1);
      check("t3_val_b", out_iss_val_b, 64'h2A);
      issue_one();

      // Same tag on both ports: port 0 wins
      ins(4'd7, 2'b10, 4'd8, 4'd0, 64'd0, 64'd9);
      bcast(0, 4'd8, 64'h11, 1'b0, 4'h0);
      bcast(1, 4'd8, 64'h22, 1'b0, 4'h0);
      tick();
      in_bc_valid = '0;
      #1;
      check("prio_val_a", out_iss_val_a, 64'h11);
      issue_one();

      // Insert-cycle bypass
      bcast(0, 4'd9, 64'd11, 1'b0, 4'h0);
      ins(4'd10, 2'b10, 4'd9, 4'd0, 64'd0, 64'd3);
      in_bc_valid = '0;
      #1;
      check("t4_iss_valid", 64'(out_iss_valid), 1);
      check("t4_val_a", out_iss_val_a, 11);
      issue_one();

      // Flag wakeup
      in_ins_uses_nzcv = 1'b1; in_ins_nzcv_valid = 1'b0; in_ins_nzcv_tag = 4'd11;
      in_ins_set_nzcv = 1'b1;
      ins(4'd12, 2'b11, 4'd0, 4'd0, 64'd1, 64'd2);
      in_ins_set_nzcv = 1'b0;
      check("nzcv_wait", 64'(out_iss_valid), 0);
      bcast(0, 4'd11, 64'd0, 1'b1, 4'hA);
      tick();
      in_bc_valid = '0; in_bc_set_nzcv = '0;
      #1;
      check("nzcv_ready", 64'(out_iss_valid), 1);
      check("nzcv_value", 64'(out_iss_nzcv), 64'hA);
      check("nzcv_set", 64'(out_iss_set_nzcv), 1);
      issue_one();
      check("nzcv_count", 64'(out_count), 0);

      // Fill to capacity
      for (int k = 0; k < 8; k++) ins(4'(k), 2'b11, 4'd0, 4'd0, 64'(k), 64'd0);
      check("t5_count_full", 64'(out_count), 8);
      check("t5_ready_full", 64'(out_ins_ready), 0);
      issue_one();
      check("t5_count_7", 64'(out_count), 7);
      check("t5_ready_again", 64'(out_ins_ready), 1);
      check("t5_next_dst", 64'(out_iss_dst), 1);
      in_iss_ready = 1'b1;
      repeat (7) tick();
      in_iss_ready = 1'b0;
      #1;
      check("t5_drained", 64'(out_count), 0);

      // Partial flush, then async reset
      ins(4'd1, 2'b11, 4'd0, 4'd0, 64'd1, 64'd0);
      ins(4'd3, 2'b11, 4'd0, 4'd0, 64'd3, 64'd0);
      ins(4'd5, 2'b11, 4'd0, 4'd0, 64'd5, 64'd0);
      ins(4'd7, 2'b11, 4'd0, 4'd0, 64'd7, 64'd0);
      check("t6_count4", 64'(out_count), 4);
      in_flush = 1'b1; in_flush_tag = 4'd3;
      #1;
      check("t6_flush_ins_ready", 64'(out_ins_ready), 0);
      check("t6_flush_iss_valid", 64'(out_iss_valid), 0);
      tick();
      in_flush = 1'b0;
      #1;
      check("t6_count2", 64'(out_count), 2);
      check("t6_dst1", 64'(out_iss_dst), 1);
      issue_one();
      check("t6_dst3", 64'(out_iss_dst), 3);
      check("t6_count1", 64'(out_count), 1);
      in_rst_n = 1'b0;
      #1;
      check("t6_async_count", 64'(out_count), 0);
      check("t6_async_iss_valid", 64'(out_iss_valid), 0);
      check("t6_async_dst", 64'(out_iss_dst), 0);
      check("t6_async_ins_ready", 64'(out_ins_ready), 0);
      tick();
      in_rst_n = 1'b1;
      tick();
      check("t6_after_release", 64'(out_count), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
